// File: rtl/encoder8_3_drain_pkg.sv
// Shared types and constants for the 8-to-3 draining encoder.
// Build option: ENC_LSB_FIRST_EN selects lowest-set-bit-first draining.
package enc_pkg;

    localparam int N      = 8;
    localparam int CODE_W = $clog2(N);

    typedef enum logic {
        IDLE,
        DRAIN
    } enc_state_t;

    typedef logic [N-1:0]      req_t;
    typedef logic [CODE_W-1:0] code_t;

endpackage

// File: rtl/encoder8_3_drain_if.sv
// Request/code handshake bundle for the draining encoder.
// master drives requests and ready; slave is the encoder itself.
interface encoder8_3_drain_if;
    import enc_pkg::*;

    req_t  d;
    logic  load;
    code_t code;
    logic  out_valid;
    logic  out_ready;
    logic  busy;
    logic  done;
    logic  zero;

    modport master (
        output d, load, out_ready,
        input  code, out_valid, busy, done, zero
    );

    modport slave (
        input  d, load, out_ready,
        output code, out_valid, busy, done, zero
    );

endinterface

// File: rtl/encoder8_3_drain_prio_enc8.sv
// Combinational 8-bit priority encoder with any-bit flag.
// Build option: ENC_LSB_FIRST_EN makes the lowest set bit win.
module prio_enc8
    import enc_pkg::*;
(
    input  req_t  req,
    output code_t code,
    output logic  any
);

    // Later loop iterations override earlier ones, so the last hit wins.
    always_comb begin
        code = '0;
        any  = |req;
`ifdef ENC_LSB_FIRST_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) code = code_t'(i);
        end
`else
        for (int i = 0; i < N; i++) begin
            if (req[i]) code = code_t'(i);
        end
`endif
    end

endmodule

// File: rtl/encoder8_3_drain.sv
// Captures an 8-bit request vector and drains it one code per handshake.
// Build option: ENC_LSB_FIRST_EN reverses drain order (lowest bit first).
module encoder8_3_drain
    import enc_pkg::*;
(
    input logic               clk,
    input logic               reset_n,
    encoder8_3_drain_if.slave bus
);

    enc_state_t state;
    enc_state_t state_nxt;
    req_t       pending;
    req_t       pending_nxt;
    logic       done_q;
    logic       done_nxt;
    logic       zero_q;
    logic       zero_nxt;
    code_t      sel;
    logic       sel_any;
    req_t       sel_mask;
    logic       valid;
    logic       fire;

    prio_enc8 u_prio (
        .req  (pending),
        .code (sel),
        .any  (sel_any)
    );

    assign sel_mask = req_t'(1) << sel;
    assign valid    = (state == DRAIN) && sel_any;
    assign fire     = valid && bus.out_ready;

    // Next-state, pending update and pulse generation.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        done_nxt    = 1'b0;
        zero_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.load) begin
                    if (bus.d != '0) begin
                        pending_nxt = bus.d;
                        state_nxt   = DRAIN;
                    end else begin
                        zero_nxt = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (fire) begin
                    pending_nxt = pending & ~sel_mask;
                    if (pending_nxt == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, pending vector and one-cycle pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pending <= '0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            done_q  <= done_nxt;
            zero_q  <= zero_nxt;
        end
    end

    assign bus.out_valid = valid;
    assign bus.code      = valid ? sel : '0;
    assign bus.busy      = (state == DRAIN);
    assign bus.done      = done_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_encoder8_3_drain.sv
// Directed self-checking bench for encoder8_3_drain.
// Expected drain orders follow ENC_LSB_FIRST_EN when defined.
module tb_encoder8_3_drain;
    import enc_pkg::*;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    encoder8_3_drain_if bus ();

    encoder8_3_drain dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        code_t first;
`ifdef ENC_LSB_FIRST_EN
        first = 3'd0;
`else
        first = 3'd7;
`endif
        reset_n = 1'b0;
        bus.d = '0;
        bus.load = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.done, bus.zero, bus.code} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_vals: got %b want 0",
                {bus.out_valid, bus.busy, bus.done, bus.zero, bus.code});
        end
        step();
        step();
        reset_n = 1'b1;
        bus.d = 8'hA5;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.code} !== {2'b11, first}) begin
            n_fail++;
            $display("FAIL reset_pre_drain: got v%b b%b c%0d want v1 b1 c%0d",
                bus.out_valid, bus.busy, bus.code, first);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.done, bus.code} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_async: got v%b b%b d%b c%0d want all 0",
                bus.out_valid, bus.busy, bus.done, bus.code);
        end
        step();
        reset_n = 1'b1;
        step();
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: got v%b b%b d%b want 000",
                bus.out_valid, bus.busy, bus.done);
        end
    endtask

    task automatic test_single();
        bus.d = 8'b0001_0000;
        bus.load = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.load = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.code} !== {2'b11, 3'd4}) begin
            n_fail++;
            $display("FAIL single_code: got v%b b%b c%0d want v1 b1 c4",
                bus.out_valid, bus.busy, bus.code);
        end
        step();
        n_checks++;
        if ({bus.out_valid, bus.done, bus.code} !== {2'b01, 3'd0}) begin
            n_fail++;
            $display("FAIL single_done: got v%b d%b c%0d want v0 d1 c0",
                bus.out_valid, bus.done, bus.code);
        end
        step();
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done_pulse: got %b want 0", bus.done);
        end
    endtask

    task automatic test_multi();
        code_t exp [4];
`ifdef ENC_LSB_FIRST_EN
        exp = '{3'd0, 3'd2, 3'd5, 3'd7};
`else
        exp = '{3'd7, 3'd5, 3'd2, 3'd0};
`endif
        bus.d = 8'hA5;
        bus.load = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({bus.out_valid, bus.done, bus.code} !== {2'b10, exp[k]}) begin
                n_fail++;
                $display("FAIL multi_code[%0d]: got v%b d%b c%0d want v1 d0 c%0d",
                    k, bus.out_valid, bus.done, bus.code, exp[k]);
            end
            step();
        end
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.done} !== 3'b001) begin
            n_fail++;
            $display("FAIL multi_done: got v%b b%b d%b want 001",
                bus.out_valid, bus.busy, bus.done);
        end
        step();
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_done_pulse: got %b want 0", bus.done);
        end
    endtask

    task automatic test_backpressure();
        code_t exp [2];
`ifdef ENC_LSB_FIRST_EN
        exp = '{3'd0, 3'd1};
`else
        exp = '{3'd1, 3'd0};
`endif
        bus.d = 8'h03;
        bus.load = 1'b1;
        bus.out_ready = 1'b0;
        step();
        bus.load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({bus.out_valid, bus.code} !== {1'b1, exp[0]}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v%b c%0d want v1 c%0d",
                    k, bus.out_valid, bus.code, exp[0]);
            end
            step();
        end
        bus.out_ready = 1'b1;
        n_checks++;
        if ({bus.out_valid, bus.code} !== {1'b1, exp[0]}) begin
            n_fail++;
            $display("FAIL bp_first: got v%b c%0d want v1 c%0d",
                bus.out_valid, bus.code, exp[0]);
        end
        step();
        n_checks++;
        if ({bus.out_valid, bus.code} !== {1'b1, exp[1]}) begin
            n_fail++;
            $display("FAIL bp_second: got v%b c%0d want v1 c%0d",
                bus.out_valid, bus.code, exp[1]);
        end
        step();
        n_checks++;
        if ({bus.out_valid, bus.done} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_done: got v%b d%b want v0 d1",
                bus.out_valid, bus.done);
        end
        step();
    endtask

    task automatic test_zero();
        bus.d = 8'h00;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        n_checks++;
        if ({bus.zero, bus.busy, bus.out_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_pulse: got z%b b%b v%b want z1 b0 v0",
                bus.zero, bus.busy, bus.out_valid);
        end
        step();
        n_checks++;
        if ({bus.zero, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL zero_clear: got z%b b%b want 00", bus.zero, bus.busy);
        end
    endtask

    task automatic test_load_busy();
        code_t exp [2];
`ifdef ENC_LSB_FIRST_EN
        exp = '{3'd2, 3'd3};
`else
        exp = '{3'd3, 3'd2};
`endif
        bus.d = 8'h0C;
        bus.load = 1'b1;
        bus.out_ready = 1'b1;
        step();
        n_checks++;
        if ({bus.out_valid, bus.code} !== {1'b1, exp[0]}) begin
            n_fail++;
            $display("FAIL lb_first: got v%b c%0d want v1 c%0d",
                bus.out_valid, bus.code, exp[0]);
        end
        bus.d = 8'hF0;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.code} !== {1'b1, exp[1]}) begin
            n_fail++;
            $display("FAIL lb_second: got v%b c%0d want v1 c%0d",
                bus.out_valid, bus.code, exp[1]);
        end
        step();
        n_checks++;
        if ({bus.out_valid, bus.done} !== 2'b01) begin
            n_fail++;
            $display("FAIL lb_done: got v%b d%b want v0 d1",
                bus.out_valid, bus.done);
        end
        step();
        n_checks++;
        if ({bus.out_valid, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL lb_ignored: got v%b b%b want 00",
                bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        code_t exp [2];
`ifdef ENC_LSB_FIRST_EN
        exp = '{3'd0, 3'd7};
`else
        exp = '{3'd7, 3'd0};
`endif
        bus.d = 8'h10;
        bus.load = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.load = 1'b0;
        step();
        n_checks++;
        if ({bus.out_valid, bus.done} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_done: got v%b d%b want v0 d1",
                bus.out_valid, bus.done);
        end
        bus.d = 8'h81;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.done, bus.code} !== {2'b10, exp[0]}) begin
            n_fail++;
            $display("FAIL b2b_first: got v%b d%b c%0d want v1 d0 c%0d",
                bus.out_valid, bus.done, bus.code, exp[0]);
        end
        step();
        n_checks++;
        if ({bus.out_valid, bus.code} !== {1'b1, exp[1]}) begin
            n_fail++;
            $display("FAIL b2b_second: got v%b c%0d want v1 c%0d",
                bus.out_valid, bus.code, exp[1]);
        end
        step();
        n_checks++;
        if ({bus.out_valid, bus.done} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_end: got v%b d%b want v0 d1",
                bus.out_valid, bus.done);
        end
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_zero();
        test_load_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
            n_checks, n_fail);
        $finish;
    end

endmodule
